alu_req_arbiter: RTL and testbench
==================================

# alu_req_arbiter

Shares the single ALU datapath among four requesters. Each requester posts a 12-bit command word (opcode in [3:0]) plus two operands. The block grants one requester at a time in round-robin order, drives the ALU load and operation strobes for the required number of cycles, and captures the ALU result. It returns that result to the granted requester over a valid/ready response channel. It sits between the requester ports and the ALU register/operation datapath, and is the only driver of the ALU control strobes.

## Interface
- DW, 8 — operand width; result width is 2*DW.
- MUL_CYC, 4 — cycles aMul is held (legal 1..15).
- DIV_CYC, 8 — cycles aDiv is held (legal 1..15).

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clock clk.
- req_valid  in  4  per-requester request; held by requester until its req_ready.
- req_cmd  in  48  four 12-bit commands; requester i uses [12i+11:12i]; opcode = bits [3:0]; bits [11:4] ignored.
- req_a, req_b  in  4*DW each  per-requester operands; requester i uses [DW*i+DW-1:DW*i].
- req_ready  out  4  one-hot acceptance pulse, one cycle.
- alu_a, alu_b  out  DW each  registered operands presented to the ALU.
- ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul  out  1 each  ALU control strobes.
- alu_res  in  2*DW  ALU result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  2  index of the requester that owns the response.
- rsp_data  out  2*DW  captured result.
- rsp_err  out  1  illegal opcode flag for this response.

## Operation
- Opcodes: 1 = CMP, 2 = ADD, 3 = SUB, 4 = DIV, 5 = MUL. All other values are illegal.
- State machine has four states: IDLE, LOAD, EXEC, RESP.
- IDLE:
  - If any req_valid is high, select a winner by round-robin. Search order is last_id+1, +2, +3, +4 (mod 4).
  - Assert req_ready[winner] for this cycle only.
  - Latch into internal registers: opcode, rsp_id = winner, alu_a/alu_b from that requester's operands.
  - Set last_id = winner.
  - Next state: LOAD for a legal opcode. For an illegal opcode go to RESP with rsp_err = 1 and rsp_data = 0.
  - No req_valid: stay in IDLE with all outputs idle.
- LOAD: ldA = ldB = 1 for exactly one cycle. Load the cycle counter with N, where N = 1 for CMP/ADD/SUB, MUL_CYC for MUL, DIV_CYC for DIV. Next state: EXEC.
- EXEC:
  - Exactly one operation strobe (the one matching the opcode) is high in every EXEC cycle. ldA and ldB are low.
  - The counter decrements once per cycle.
  - In the EXEC cycle where counter == 1, sample alu_res into rsp_data on that cycle's closing edge, then go to RESP.
- RESP: rsp_valid = 1; rsp_id, rsp_data and rsp_err hold steady. On rsp_valid && rsp_ready, go to IDLE. With no rsp_ready, stay in RESP indefinitely.
- alu_a and alu_b hold their latched values from the grant through RESP and change only at the next grant.
- req_valid and req_cmd are sampled only in IDLE. Changes in any other state are ignored; a request that drops before being granted is never served.
- At most one of req_ready, ldA/ldB, the op strobes and rsp_valid is active in any cycle: req_ready only in IDLE, ldA/ldB only in LOAD, op strobes only in EXEC, rsp_valid only in RESP.

## Timing
- Reset (asynchronous, active-low) forces:
  - state = IDLE, last_id = 3 (so requester 0 wins first);
  - every output = 0, counter = 0.
- Reset mid-operation drops the in-flight command and any pending response without a response. After reset release, the first grant follows normal IDLE rules.
- Let the grant cycle be T. Then LOAD is T+1, EXEC spans T+2 .. T+1+N, and rsp_valid first rises at T+2+N.
  - ADD (N = 1): rsp_valid at T+3.
  - MUL with default MUL_CYC (N = 4): rsp_valid at T+6.
  - DIV with default DIV_CYC (N = 8): rsp_valid at T+10.
- Illegal opcode: rsp_valid at T+1, with no LOAD and no EXEC strobes.
- After the rsp_valid && rsp_ready edge there is one IDLE cycle before the next grant. Minimum grant-to-grant spacing is therefore N+3 cycles, assuming rsp_ready stays high.
- The arithmetic width of the response is exactly 2*DW bits of alu_res, captured with no truncation or extension.

## Test plan
- Reset then a single ADD from requester 2 (a = 8'h05, b = 8'h03, ALU model returns 16'h0008):
  - req_ready = 4'b0100 at T; ldA/ldB at T+1; aAdd at T+2 only;
  - rsp_valid at T+3 with rsp_id = 2, rsp_data = 16'h0008, rsp_err = 0.
- All four req_valid held high continuously, rsp_ready tied 1: grants occur in order 0, 1, 2, 3, 0. Each grant waits for the previous response handshake.
- MUL from requester 1 with MUL_CYC = 4: aMul is high for exactly 4 consecutive cycles, and rsp_valid rises at T+6. DIV with DIV_CYC = 8: aDiv is high for 8 cycles, and rsp_valid rises at T+10.
- Opcode 4'b1111 from requester 3: req_ready = 4'b1000, no strobes, rsp_valid at T+1 with rsp_err = 1 and rsp_data = 0. The next grant goes to requester 0.
- rsp_ready held low for 5 cycles in RESP: rsp_valid, rsp_id and rsp_data stay stable. No req_ready is issued despite pending req_valid. The handshake then completes and the next grant follows one cycle later.
- reset asserted during the 3rd EXEC cycle of a DIV:
  - all outputs are 0 immediately, with no response;
  - after release, requester 0 wins if it is requesting.

Source files
------------

// File: rtl/alu_req_arbiter_if.sv
// Signal bundle between the four ALU requesters, the ALU control datapath and
// the response consumer. The arbiter uses the master view, the environment the slave view.
interface alu_req_arbiter_if #(
  parameter int DW = 8
);
  logic [3:0]      req_valid;
  logic [47:0]     req_cmd;
  logic [4*DW-1:0] req_a;
  logic [4*DW-1:0] req_b;
  logic [3:0]      req_ready;

  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic            ldA;
  logic            ldB;
  logic            aCmp;
  logic            aAdd;
  logic            aSub;
  logic            aDiv;
  logic            aMul;
  logic [2*DW-1:0] alu_res;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [2*DW-1:0] rsp_data;
  logic            rsp_err;

  modport master (
    input  req_valid, req_cmd, req_a, req_b, alu_res, rsp_ready,
    output req_ready, alu_a, alu_b, ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul,
           rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_cmd, req_a, req_b, alu_res, rsp_ready,
    input  req_ready, alu_a, alu_b, ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul,
           rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU among four requesters: grants a command,
// sequences the ALU load/operation strobes, captures the result and returns it.
module alu_req_arbiter #(
  parameter int DW      = 8,
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 8
) (
  input logic               clk,
  input logic               reset,
  alu_req_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} stateT;

  localparam logic [3:0] OpCmp = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpDiv = 4'd4;
  localparam logic [3:0] OpMul = 4'd5;

  stateT      state;
  logic [1:0] lastId;
  logic [3:0] opcode;
  logic [3:0] cycCnt;

  logic       grantValid;
  logic [1:0] grantId;
  logic [1:0] probeId;
  logic [3:0] grantOp;
  logic       grantLegal;

  function automatic logic [3:0] execCycles(input logic [3:0] op);
    case (op)
      OpMul:   return 4'(MUL_CYC);
      OpDiv:   return 4'(DIV_CYC);
      default: return 4'd1;
    endcase
  endfunction

  // Probe lastId+4 down to lastId+1 so the nearest requester after lastId wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grantValid = 1'b0;
    grantId    = lastId;
    probeId    = lastId;
    for (int k = 4; k >= 1; k--) begin
      probeId = lastId + 2'(k);
      if (bus.req_valid[probeId]) begin
        grantValid = 1'b1;
        grantId    = probeId;
      end
    end
  end

  assign grantOp    = bus.req_cmd[12*grantId +: 4];
  assign grantLegal = (grantOp >= OpCmp) && (grantOp <= OpMul);

  // The grant pulse must appear in the same IDLE cycle the request is seen,
  // so it is decoded rather than registered; reset masks it so outputs read 0.
  assign bus.req_ready = (reset && state == IDLE && grantValid) ? (4'b0001 << grantId) : 4'b0000;

  // NOTE: state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      lastId        <= 2'd3;
      opcode        <= 4'd0;
      cycCnt        <= 4'd0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.ldA       <= 1'b0;
      bus.ldB       <= 1'b0;
      bus.aCmp      <= 1'b0;
      bus.aAdd      <= 1'b0;
      bus.aSub      <= 1'b0;
      bus.aDiv      <= 1'b0;
      bus.aMul      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 2'd0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grantValid) begin
            lastId     <= grantId;
            opcode     <= grantOp;
            bus.rsp_id <= grantId;
            bus.alu_a  <= bus.req_a[DW*grantId +: DW];
            bus.alu_b  <= bus.req_b[DW*grantId +: DW];
            if (grantLegal) begin
              state       <= LOAD;
              bus.ldA     <= 1'b1;
              bus.ldB     <= 1'b1;
              bus.rsp_err <= 1'b0;
            end else begin
              // Illegal opcodes skip the ALU entirely and answer with an error.
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
            end
          end
        end

        LOAD: begin
          state    <= EXEC;
          bus.ldA  <= 1'b0;
          bus.ldB  <= 1'b0;
          cycCnt   <= execCycles(opcode);
          bus.aCmp <= (opcode == OpCmp);
          bus.aAdd <= (opcode == OpAdd);
          bus.aSub <= (opcode == OpSub);
          bus.aDiv <= (opcode == OpDiv);
          bus.aMul <= (opcode == OpMul);
        end

        EXEC: begin
          cycCnt <= cycCnt - 4'd1;
          if (cycCnt == 4'd1) begin
            state         <= RESP;
            bus.rsp_data  <= bus.alu_res;
            bus.rsp_valid <= 1'b1;
            bus.aCmp      <= 1'b0;
            bus.aAdd      <= 1'b0;
            bus.aSub      <= 1'b0;
            bus.aDiv      <= 1'b0;
            bus.aMul      <= 1'b0;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized bench for alu_req_arbiter: a transaction-level model predicts the
// round-robin winner, strobe schedule and response of every grant.
module tb_alu_req_arbiter;
  localparam int DW      = 8;
  localparam int MUL_CYC = 4;
  localparam int DIV_CYC = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_req_arbiter_if #(.DW(DW)) bus ();

  alu_req_arbiter #(.DW(DW), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Requester-side state seen by the model.
  bit         pend[4];
  logic [3:0] cmdOp[4];
  logic [7:0] opA[4];
  logic [7:0] opB[4];
  logic [7:0] junk[4];
  int         modelLast;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] refAlu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd1:    return {14'd0, a > b, a == b};
      4'd2:    return 16'(a) + 16'(b);
      4'd3:    return 16'(a) - 16'(b);
      4'd4:    return (b == 8'd0) ? 16'hFFFF : {a % b, a / b};
      4'd5:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int opCycles(input logic [3:0] op);
    if (op == 4'd5) return MUL_CYC;
    if (op == 4'd4) return DIV_CYC;
    return 1;
  endfunction

  // ALU stand-in: the result is only correct once the strobe has been held
  // for the full operation length, otherwise it reads as a poison value.
  logic [3:0] aluOp;
  int         aluRun;

  always_comb begin
    aluOp = 4'd0;
    if (bus.aCmp) aluOp = 4'd1;
    if (bus.aAdd) aluOp = 4'd2;
    if (bus.aSub) aluOp = 4'd3;
    if (bus.aDiv) aluOp = 4'd4;
    if (bus.aMul) aluOp = 4'd5;
    bus.alu_res = (aluOp != 4'd0 && aluRun + 1 == opCycles(aluOp))
                  ? refAlu(aluOp, bus.alu_a, bus.alu_b) : 16'hEEEE;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) aluRun <= 0;
    else        aluRun <= (aluOp != 4'd0) ? aluRun + 1 : 0;
  end

  function automatic logic [11:0] ctlVec();
    return {bus.req_ready, bus.ldA, bus.ldB, bus.aCmp, bus.aAdd, bus.aSub,
            bus.aDiv, bus.aMul, bus.rsp_valid};
  endfunction

  function automatic logic [11:0] expCtl(input logic [3:0] rdy, input logic ld,
                                         input logic [4:0] stb, input logic rv);
    return {rdy, ld, ld, stb, rv};
  endfunction

  function automatic logic [4:0] opStb(input logic [3:0] op);
    return 5'b10000 >> (op - 4'd1);
  endfunction

  function automatic int pickWinner();
    for (int k = 1; k <= 4; k++) begin
      if (pend[(modelLast + k) % 4]) return (modelLast + k) % 4;
    end
    return -1;
  endfunction

  task automatic setReq(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    pend[i]  = 1'b1;
    cmdOp[i] = op;
    opA[i]   = a;
    opB[i]   = b;
    junk[i]  = 8'($urandom);
  endtask

  task automatic newReq(input int i);
    int v;
    logic [3:0] op;
    if ($urandom_range(0, 7) == 0) begin
      v  = $urandom_range(6, 16);
      op = (v == 16) ? 4'd0 : 4'(v);
    end else begin
      op = 4'($urandom_range(1, 5));
    end
    setReq(i, op, 8'($urandom), 8'($urandom));
  endtask

  // mode 0: leave requests alone, 1: random arrivals/withdrawals, 2: keep all requesting
  task automatic stir(input int mode);
    for (int i = 0; i < 4; i++) begin
      if (mode == 2 && !pend[i]) newReq(i);
      if (mode == 1) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) newReq(i);
        else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
      end
    end
  endtask

  task automatic applyInputs();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i]        = pend[i];
      bus.req_cmd[12*i +: 12] = {junk[i], cmdOp[i]};
      bus.req_a[8*i +: 8]     = opA[i];
      bus.req_b[8*i +: 8]     = opB[i];
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_ctl"},   32'(ctlVec()), 32'd0);
    check({tag, "_alu"},   32'({bus.alu_a, bus.alu_b}), 32'd0);
    check({tag, "_data"},  32'(bus.rsp_data), 32'd0);
    check({tag, "_iderr"}, 32'({bus.rsp_id, bus.rsp_err}), 32'd0);
  endtask

  // One whole transaction: wait for the predicted grant, then check every cycle
  // of its schedule up to the response handshake (or reset at cycle abortAt).
  task automatic runTxn(input int rspHold, input int mode, input int abortAt,
                        output int winner, output logic [15:0] gotData);
    int w, n, hold, waited;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [15:0] expData;
    logic [11:0] exp;
    bit illegal, inResp, done;
    w = -1; waited = 0; winner = -1; gotData = 16'h0; done = 1'b0;
    while (w < 0) begin
      @(negedge clk);
      stir(mode);
      bus.rsp_ready = 1'($urandom);
      applyInputs();
      #1;
      w = pickWinner();
      if (w < 0) begin
        check("idle_ctl", 32'(ctlVec()), 32'd0);
        waited++;
        if (waited > 64) begin
          check("grant_timeout", 32'(waited), 32'd0);
          return;
        end
      end
    end
    check("grant_ctl", 32'(ctlVec()), 32'(expCtl(4'b0001 << w, 1'b0, 5'b0, 1'b0)));
    op = cmdOp[w]; a = opA[w]; b = opB[w];
    modelLast = w; pend[w] = 1'b0; winner = w;
    illegal = !(op >= 4'd1 && op <= 4'd5);
    n       = illegal ? 0 : opCycles(op);
    expData = illegal ? 16'h0 : refAlu(op, a, b);
    hold    = (rspHold < 0) ? $urandom_range(0, 3) : rspHold;
    for (int c = 1; c < 100 && !done; c++) begin
      @(negedge clk);
      stir(mode);
      inResp = illegal || (c >= n + 2);
      if (inResp) begin
        bus.rsp_ready = (hold == 0);
        if (hold > 0) hold--;
      end else begin
        bus.rsp_ready = 1'($urandom);
      end
      applyInputs();
      #1;
      if (inResp)      exp = expCtl(4'b0, 1'b0, 5'b0, 1'b1);
      else if (c == 1) exp = expCtl(4'b0, 1'b1, 5'b0, 1'b0);
      else             exp = expCtl(4'b0, 1'b0, opStb(op), 1'b0);
      check("ctl", 32'(ctlVec()), 32'(exp));
      check("alu_ab", 32'({bus.alu_a, bus.alu_b}), 32'({a, b}));
      if (inResp) begin
        check("rsp_id",   32'(bus.rsp_id), 32'(w));
        check("rsp_data", 32'(bus.rsp_data), 32'(expData));
        check("rsp_err",  32'(bus.rsp_err), 32'(illegal));
        gotData = bus.rsp_data;
        done    = bus.rsp_ready;
      end
      if (c == abortAt) begin
        reset = 1'b0;
        #1;
        checkAllZero("abort");
        return;
      end
    end
    if (!done) check("rsp_timeout", 32'(done), 32'd1);
  endtask

  int w;
  logic [15:0] d;

  initial begin
    reset = 1'b0;
    modelLast = 3;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0; cmdOp[i] = 4'd0; opA[i] = 8'd0; opB[i] = 8'd0; junk[i] = 8'd0;
    end
    bus.rsp_ready = 1'b0;
    applyInputs();
    #3;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Single ADD from requester 2.
    setReq(2, 4'd2, 8'h05, 8'h03);
    runTxn(0, 0, 0, w, d);
    check("add_winner", 32'(w), 32'd2);
    check("add_data", 32'(d), 32'h0008);

    // Illegal opcode from requester 3, then a MUL from 0 with a stalled response.
    setReq(3, 4'hF, 8'h12, 8'h34);
    setReq(0, 4'd5, 8'h0C, 8'h0B);
    runTxn(0, 0, 0, w, d);
    check("ill_winner", 32'(w), 32'd3);
    check("ill_data", 32'(d), 32'd0);
    runTxn(5, 0, 0, w, d);
    check("mul_winner", 32'(w), 32'd0);
    check("mul_data", 32'(d), 32'd132);

    // DIV from requester 1.
    setReq(1, 4'd4, 8'd200, 8'd7);
    runTxn(0, 0, 0, w, d);
    check("div_winner", 32'(w), 32'd1);
    check("div_data", 32'(d), 32'h041C);

    // Reset in the third EXEC cycle of a DIV from requester 2.
    setReq(2, 4'd4, 8'd99, 8'd5);
    runTxn(0, 0, 4, w, d);
    modelLast = 3;
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    setReq(0, 4'd2, 8'd1, 8'd1);
    applyInputs();
    #1;
    check("rst_gate", 32'(ctlVec()), 32'd0);
    pend[0] = 1'b0;
    applyInputs();
    @(negedge clk);
    reset = 1'b1;

    // Everyone requesting continuously: strict 0,1,2,3,0 rotation.
    for (int k = 0; k < 5; k++) begin
      runTxn(0, 2, 0, w, d);
      check("rr_order", 32'(w), 32'(k % 4));
    end

    // Random arrivals, withdrawals, opcodes and response back-pressure.
    for (int k = 0; k < 40; k++) runTxn(-1, 1, 0, w, d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
